// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory burst arbiter.
// Channel numbering doubles as the round-robin search order.
package mem_arb_pkg;
    localparam int NUM_CH = 4;

    localparam logic [1:0] CH_RD0 = 2'd0;
    localparam logic [1:0] CH_RD1 = 2'd1;
    localparam logic [1:0] CH_WR0 = 2'd2;
    localparam logic [1:0] CH_WR1 = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } arb_state_t;
endpackage

// File: rtl/mem_burst_arbiter_rr_pick4.sv
// Combinational 4-way round-robin selector: the search starts at ptr+1,
// so the channel at ptr itself has the lowest priority.
module rr_pick4
    import mem_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        ptr,
    output logic              valid,
    output logic [1:0]        idx
);
    logic [1:0] cand_s;

    // Walk from lowest to highest priority so the last hit wins
    always_comb begin
        valid  = 1'b0;
        idx    = ptr;
        cand_s = ptr;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand_s = ptr + k[1:0];
            idx    = req[cand_s] ? cand_s : idx;
            valid  = valid | req[cand_s];
        end
    end
endmodule

// File: rtl/mem_burst_arbiter.sv
// Shares one memory-controller burst interface between two read and two
// write burst masters, one burst at a time in round-robin order.
module mem_burst_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BITS  = 23,
    parameter int BURST_BITS = 10,
    parameter int TIMEOUT    = 65535
) (
    input  logic                    mem_clk,
    input  logic                    rst,
    input  logic [1:0]              c_rd_req,
    input  logic [2*BURST_BITS-1:0] c_rd_len,
    input  logic [2*ADDR_BITS-1:0]  c_rd_addr,
    output logic [1:0]              c_rd_data_valid,
    output logic [1:0]              c_rd_finish,
    input  logic [1:0]              c_wr_req,
    input  logic [2*BURST_BITS-1:0] c_wr_len,
    input  logic [2*ADDR_BITS-1:0]  c_wr_addr,
    output logic [1:0]              c_wr_data_req,
    output logic [1:0]              c_wr_finish,
    output logic                    rd_burst_req,
    output logic [BURST_BITS-1:0]   rd_burst_len,
    output logic [ADDR_BITS-1:0]    rd_burst_addr,
    input  logic                    rd_burst_data_valid,
    input  logic                    rd_burst_finish,
    output logic                    wr_burst_req,
    output logic [BURST_BITS-1:0]   wr_burst_len,
    output logic [ADDR_BITS-1:0]    wr_burst_addr,
    input  logic                    wr_burst_data_req,
    input  logic                    wr_burst_finish,
    output logic [2:0]              grant_id,
    output logic                    timeout_err
);
    localparam int                  CNT_BITS = $clog2(TIMEOUT + 1);
    localparam logic [CNT_BITS-1:0] TMO_MAX  = CNT_BITS'(TIMEOUT);
    localparam logic [CNT_BITS-1:0] TMO_LAST = CNT_BITS'(TIMEOUT - 1);

    arb_state_t          state_r;
    arb_state_t          state_s;
    logic [1:0]          ptr_r;
    logic [1:0]          gnt_ch_r;
    logic [CNT_BITS-1:0] tmo_cnt_r;
    logic                pick_valid_s;
    logic [1:0]          pick_idx_s;
    logic                ctl_first_s;
    logic                ctl_finish_s;
    logic [1:0]          rd_route_s;
    logic [1:0]          wr_route_s;

    rr_pick4 u_pick (
        .req   ({c_wr_req, c_rd_req}),
        .ptr   (ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Only the granted side's controller handshakes matter; the other side is ignored
    assign ctl_first_s  = gnt_ch_r[1] ? wr_burst_data_req : rd_burst_data_valid;
    assign ctl_finish_s = gnt_ch_r[1] ? wr_burst_finish   : rd_burst_finish;

    assign rd_route_s = ((state_r == S_BURST) && !gnt_ch_r[1]) ? (2'b01 << gnt_ch_r[0]) : 2'b00;
    assign wr_route_s = ((state_r == S_BURST) &&  gnt_ch_r[1]) ? (2'b01 << gnt_ch_r[0]) : 2'b00;

    assign c_rd_data_valid = rd_route_s & {2{rd_burst_data_valid}};
    assign c_rd_finish     = rd_route_s & {2{rd_burst_finish}};
    assign c_wr_data_req   = wr_route_s & {2{wr_burst_data_req}};
    assign c_wr_finish     = wr_route_s & {2{wr_burst_finish}};

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (pick_valid_s) state_s = S_BURST;
                else              state_s = S_IDLE;
            end
            S_BURST: begin
                if (ctl_finish_s) state_s = S_GAP;
                else              state_s = S_BURST;
            end
            S_GAP:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_s;
    end

    // Grant capture, controller request, pointer and timeout bookkeeping
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            ptr_r         <= 2'd3;
            gnt_ch_r      <= 2'd0;
            tmo_cnt_r     <= {CNT_BITS{1'b0}};
            grant_id      <= 3'b000;
            timeout_err   <= 1'b0;
            rd_burst_req  <= 1'b0;
            rd_burst_len  <= {BURST_BITS{1'b0}};
            rd_burst_addr <= {ADDR_BITS{1'b0}};
            wr_burst_req  <= 1'b0;
            wr_burst_len  <= {BURST_BITS{1'b0}};
            wr_burst_addr <= {ADDR_BITS{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (pick_valid_s) begin
                        gnt_ch_r  <= pick_idx_s;
                        grant_id  <= {1'b1, pick_idx_s};
                        tmo_cnt_r <= {CNT_BITS{1'b0}};
                        if (pick_idx_s[1]) begin
                            wr_burst_req  <= 1'b1;
                            wr_burst_len  <= pick_idx_s[0] ? c_wr_len[2*BURST_BITS-1:BURST_BITS]
                                                           : c_wr_len[BURST_BITS-1:0];
                            wr_burst_addr <= pick_idx_s[0] ? c_wr_addr[2*ADDR_BITS-1:ADDR_BITS]
                                                           : c_wr_addr[ADDR_BITS-1:0];
                        end else begin
                            rd_burst_req  <= 1'b1;
                            rd_burst_len  <= pick_idx_s[0] ? c_rd_len[2*BURST_BITS-1:BURST_BITS]
                                                           : c_rd_len[BURST_BITS-1:0];
                            rd_burst_addr <= pick_idx_s[0] ? c_rd_addr[2*ADDR_BITS-1:ADDR_BITS]
                                                           : c_rd_addr[ADDR_BITS-1:0];
                        end
                    end
                end
                S_BURST: begin
                    // Saturating count; the error stays sticky, the controller owns recovery
                    if (tmo_cnt_r != TMO_MAX)  tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    if (tmo_cnt_r == TMO_LAST) timeout_err <= 1'b1;
                    if (ctl_first_s || ctl_finish_s) begin
                        rd_burst_req <= 1'b0;
                        wr_burst_req <= 1'b0;
                    end
                    if (ctl_finish_s) begin
                        ptr_r    <= gnt_ch_r;
                        grant_id <= 3'b000;
                    end
                end
                S_GAP: begin
                    grant_id <= 3'b000;
                end
                default: begin
                    grant_id <= 3'b000;
                end
            endcase
        end
    end
endmodule
